// File: rtl/irq_nest_ctrl.sv
// Nested-priority interrupt controller: latch, mask, arbitrate against the in-service level.
// Latency: pending registers on the clock after the request; int_req/int_id/int_vector are combinational.
// No backpressure: requests wait in pending until the core acks them; an ack with no request is ignored.
module irq_nest_ctrl #(
    parameter int          N_IRQ    = 3,
    parameter int          ID_W     = 2,
    parameter logic [31:0] VEC_BASE = 32'h0000_0100,
    parameter logic [31:0] VEC_STEP = 32'h0000_0040
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [N_IRQ-1:0] irq,
    input  logic [N_IRQ-1:0] trig_edge,
    input  logic [N_IRQ-1:0] irq_mask,
    input  logic             gie,
    input  logic             int_ack,
    input  logic             eret,
    output logic             int_req,
    output logic [ID_W-1:0]  int_id,
    output logic [31:0]      int_vector,
    output logic [N_IRQ-1:0] in_service,
    output logic [N_IRQ-1:0] pending,
    output logic [N_IRQ-1:0] lost
);

    logic [N_IRQ-1:0] irq_q;
    logic [N_IRQ-1:0] irq_edge;
    logic [N_IRQ-1:0] cand;
    logic [N_IRQ-1:0] pending_nxt;
    logic [N_IRQ-1:0] lost_nxt;
    logic [N_IRQ-1:0] in_service_nxt;
    logic [ID_W-1:0]  top_idx;
    logic [ID_W-1:0]  cur_idx;
    logic             has_cand;
    logic             has_cur;
    logic             take;

    assign irq_edge = irq & ~irq_q;
    assign cand     = pending & irq_mask;

    // Ascending scans leave the highest set index behind.
    always_comb begin
        top_idx  = '0;
        has_cand = 1'b0;
        cur_idx  = '0;
        has_cur  = 1'b0;
        for (int i = 0; i < N_IRQ; i++) begin
            if (cand[i]) begin
                top_idx  = ID_W'(i);
                has_cand = 1'b1;
            end
            if (in_service[i]) begin
                cur_idx = ID_W'(i);
                has_cur = 1'b1;
            end
        end
    end

    assign int_req    = gie & has_cand & (~has_cur | (top_idx > cur_idx));
    assign int_id     = has_cand ? top_idx : '0;
    assign int_vector = VEC_BASE + (32'(int_id) * VEC_STEP);
    assign take       = int_ack & int_req;

    always_comb begin
        pending_nxt    = pending;
        lost_nxt       = lost;
        in_service_nxt = in_service;
        for (int i = 0; i < N_IRQ; i++) begin
            if (trig_edge[i]) begin
                // A new edge on the ack cycle is kept as a fresh request, not counted as lost.
                if (irq_edge[i]) begin
                    pending_nxt[i] = 1'b1;
                    if (pending[i] && !(take && int_id == ID_W'(i)))
                        lost_nxt[i] = 1'b1;
                end else if (take && int_id == ID_W'(i)) begin
                    pending_nxt[i] = 1'b0;
                end
            end else begin
                pending_nxt[i] = irq[i];
            end
        end
        // ERET unwinds the old mask first, then the newly acked level is entered.
        if (eret && has_cur)
            in_service_nxt[cur_idx] = 1'b0;
        if (take)
            in_service_nxt[int_id] = 1'b1;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            irq_q      <= '0;
            pending    <= '0;
            lost       <= '0;
            in_service <= '0;
        end else begin
            irq_q      <= irq;
            pending    <= pending_nxt;
            lost       <= lost_nxt;
            in_service <= in_service_nxt;
        end
    end

endmodule

// File: tb/tb_irq_nest_ctrl.sv
// Directed bench for irq_nest_ctrl with hand-computed expectations.
module tb_irq_nest_ctrl;

    logic        clk;
    logic        clr;
    logic [2:0]  irq;
    logic [2:0]  trig_edge;
    logic [2:0]  irq_mask;
    logic        gie;
    logic        int_ack;
    logic        eret;
    logic        int_req;
    logic [1:0]  int_id;
    logic [31:0] int_vector;
    logic [2:0]  in_service;
    logic [2:0]  pending;
    logic [2:0]  lost;

    int errors = 0;
    int checks = 0;

    irq_nest_ctrl dut (
        .clk        (clk),
        .clr        (clr),
        .irq        (irq),
        .trig_edge  (trig_edge),
        .irq_mask   (irq_mask),
        .gie        (gie),
        .int_ack    (int_ack),
        .eret       (eret),
        .int_req    (int_req),
        .int_id     (int_id),
        .int_vector (int_vector),
        .in_service (in_service),
        .pending    (pending),
        .lost       (lost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [2:0] lines);
        irq = lines;
        step();
        irq = 3'b000;
    endtask

    task automatic ack();
        int_ack = 1'b1;
        step();
        int_ack = 1'b0;
    endtask

    task automatic do_eret();
        eret = 1'b1;
        step();
        eret = 1'b0;
    endtask

    initial begin
        clr = 1'b1; irq = 3'b000; trig_edge = 3'b111; irq_mask = 3'b111;
        gie = 1'b1; int_ack = 1'b0; eret = 1'b0;
        #12;
        check("rst_req", 32'(int_req), 32'd0);
        check("rst_id", 32'(int_id), 32'd0);
        check("rst_vec", int_vector, 32'h100);
        check("rst_ins", 32'(in_service), 32'd0);
        check("rst_pend", 32'(pending), 32'd0);
        clr = 1'b0;
        step();

        // 1: single request, gie gating, ack and eret
        pulse(3'b001);
        check("t1_req", 32'(int_req), 32'd1);
        check("t1_id", 32'(int_id), 32'd0);
        check("t1_vec", int_vector, 32'h100);
        gie = 1'b0; #1;
        check("t1_gie_off_req", 32'(int_req), 32'd0);
        check("t1_gie_off_pend", 32'(pending), 32'b001);
        gie = 1'b1; irq_mask = 3'b110; #1;
        check("t1_masked_req", 32'(int_req), 32'd0);
        irq_mask = 3'b111; #1;
        ack();
        check("t1_ack_ins", 32'(in_service), 32'b001);
        check("t1_ack_req", 32'(int_req), 32'd0);
        check("t1_ack_pend", 32'(pending), 32'b000);
        do_eret();
        check("t1_eret_ins", 32'(in_service), 32'b000);
        do_eret();
        check("t1_eret_idle", 32'(in_service), 32'b000);

        // 2: nesting 0 -> 1 -> 2, then unwinding
        pulse(3'b001); ack();
        pulse(3'b010);
        check("t2_req1", 32'(int_req), 32'd1);
        check("t2_id1", 32'(int_id), 32'd1);
        check("t2_vec1", int_vector, 32'h140);
        ack();
        check("t2_ins011", 32'(in_service), 32'b011);
        pulse(3'b100);
        check("t2_id2", 32'(int_id), 32'd2);
        check("t2_vec2", int_vector, 32'h180);
        ack();
        check("t2_ins111", 32'(in_service), 32'b111);
        do_eret();
        check("t2_eret1", 32'(in_service), 32'b011);
        do_eret();
        check("t2_eret2", 32'(in_service), 32'b001);
        do_eret();
        check("t2_eret3", 32'(in_service), 32'b000);

        // 3: lower priority waits behind in-service level
        pulse(3'b100); ack();
        check("t3_ins", 32'(in_service), 32'b100);
        int_ack = 1'b1; #1;
        pulse(3'b001);
        int_ack = 1'b0; #1;
        check("t3_blocked_req", 32'(int_req), 32'd0);
        check("t3_pend", 32'(pending), 32'b001);
        check("t3_ins_kept", 32'(in_service), 32'b100);
        do_eret();
        check("t3_req_after", 32'(int_req), 32'd1);
        check("t3_id_after", 32'(int_id), 32'd0);
        ack(); do_eret();

        // 4: simultaneous ch0 and ch2
        pulse(3'b101);
        check("t4_id2", 32'(int_id), 32'd2);
        ack();
        check("t4_ins", 32'(in_service), 32'b100);
        check("t4_pend", 32'(pending), 32'b001);
        check("t4_req_blk", 32'(int_req), 32'd0);
        do_eret();
        check("t4_req0", 32'(int_req), 32'd1);
        check("t4_id0", 32'(int_id), 32'd0);
        ack(); do_eret();
        check("t4_clean", 32'(in_service), 32'b000);

        // 5: edge on ack cycle is kept; edge while pending is lost
        pulse(3'b010);
        step();
        irq = 3'b010; int_ack = 1'b1;
        step();
        irq = 3'b000; int_ack = 1'b0;
        check("t5_pend_kept", 32'(pending), 32'b010);
        check("t5_lost0", 32'(lost), 32'b000);
        check("t5_ins", 32'(in_service), 32'b010);
        step();
        pulse(3'b010);
        check("t5_lost1", 32'(lost), 32'b010);
        do_eret();
        check("t5_req_again", 32'(int_req), 32'd1);
        ack(); do_eret();
        check("t5_lost_sticky", 32'(lost), 32'b010);

        // 6: level mode and asynchronous reset mid-handler
        trig_edge = 3'b101;
        irq = 3'b010;
        step();
        check("t6_req", 32'(int_req), 32'd1);
        check("t6_id", 32'(int_id), 32'd1);
        ack();
        check("t6_ins", 32'(in_service), 32'b010);
        check("t6_pend_lvl", 32'(pending), 32'b010);
        do_eret();
        check("t6_req_persist", 32'(int_req), 32'd1);
        irq = 3'b000;
        step();
        check("t6_drop_pend", 32'(pending), 32'b000);
        check("t6_drop_req", 32'(int_req), 32'd0);
        irq = 3'b010;
        step();
        ack();
        pulse(3'b100);
        ack();
        check("t6_pre_rst_ins", 32'(in_service), 32'b110);
        #2;
        clr = 1'b1;
        #1;
        check("t6_rst_req", 32'(int_req), 32'd0);
        check("t6_rst_id", 32'(int_id), 32'd0);
        check("t6_rst_vec", int_vector, 32'h100);
        check("t6_rst_ins", 32'(in_service), 32'b000);
        check("t6_rst_pend", 32'(pending), 32'b000);
        check("t6_rst_lost", 32'(lost), 32'b000);
        irq = 3'b000;
        step();
        clr = 1'b0;
        step();
        check("t6_post_rst_req", 32'(int_req), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
